// File: rtl/offnariscv_trace_monitor_if.sv
// rtl/offnariscv_trace_monitor_if.sv - AXI-Stream style event port for the trace monitor
// Carries one serialised trace event per beat from the monitor to the host-side sink.
interface offnariscv_trace_monitor_if #(
  parameter int EV_WIDTH = 101
);
  logic                tvalid;
  logic                tready;
  logic [EV_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/offnariscv_trace_monitor.sv
// rtl/offnariscv_trace_monitor.sv - pipeline event tracer with timestamped AXIS event stream
// Captures stage acceptances, retirements and flush ranges into slots, arbitrates them into a FIFO.
module offnariscv_trace_monitor #(
  parameter int NUM_STAGES = 6,
  parameter int ID_WIDTH   = 64,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_STAGES-1:0]          stage_ack,
  input  logic [NUM_STAGES*ID_WIDTH-1:0] stage_id,
  input  logic                           retire_valid,
  input  logic [ID_WIDTH-1:0]            retire_id,
  input  logic                           flush_valid,
  input  logic [ID_WIDTH-1:0]            flush_first_id,
  input  logic [ID_WIDTH-1:0]            flush_last_id,
  offnariscv_trace_monitor_if.master     m,
  output logic [15:0]                    drop_count,
  output logic                           busy
);

  localparam int STAGE_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int EV_WIDTH = 2 + STAGE_W + ID_WIDTH + TS_WIDTH;
  localparam int NSLOT    = NUM_STAGES + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [1:0] KIND_STAGE    = 2'd0;
  localparam logic [1:0] KIND_RETIRE   = 2'd1;
  localparam logic [1:0] KIND_FLUSH    = 2'd2;
  localparam logic [1:0] KIND_OVERFLOW = 2'd3;

  typedef enum logic {IDLE, WALK} walk_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Assertion is immediate; release is re-timed so every flop leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  logic [TS_WIDTH-1:0] ts;

  logic [NSLOT-1:0]    slot_v;
  logic [ID_WIDTH-1:0] slot_id [NSLOT];
  logic [TS_WIDTH-1:0] slot_ts [NSLOT];
  logic [NSLOT-1:0]    pulse;
  logic [ID_WIDTH-1:0] pulse_id [NSLOT];

  walk_state_t         state;
  logic [ID_WIDTH-1:0] walk_cur;
  logic [ID_WIDTH-1:0] walk_last;
  logic [TS_WIDTH-1:0] walk_ts;

  logic [15:0] ovf_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] n_drop;

  logic [EV_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;
  logic                room;

  logic                wr_en;
  logic [EV_WIDTH-1:0] wr_data;
  logic                grant_ovf;
  logic                grant_flush;
  logic [NSLOT-1:0]    grant_slot;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && m.tready;
  // A full FIFO still accepts a write in the same cycle it is being drained.
  assign room       = !fifo_full || pop;

  // Slot NUM_STAGES is the retire slot; the rest map one-to-one onto stages.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      pulse[i]    = stage_ack[i];
      pulse_id[i] = stage_id[i*ID_WIDTH +: ID_WIDTH];
    end
    pulse[NUM_STAGES]    = retire_valid;
    pulse_id[NUM_STAGES] = retire_id;
  end

  always_comb begin
    wr_en       = 1'b0;
    wr_data     = '0;
    grant_ovf   = 1'b0;
    grant_flush = 1'b0;
    grant_slot  = '0;
    if (room) begin
      if (ovf_cnt != 16'd0) begin
        grant_ovf = 1'b1;
        wr_en     = 1'b1;
        wr_data   = {KIND_OVERFLOW, STAGE_W'(0), ID_WIDTH'(ovf_cnt), ts};
      end else if (state == WALK) begin
        grant_flush = 1'b1;
        wr_en       = 1'b1;
        wr_data     = {KIND_FLUSH, STAGE_W'(0), walk_cur, walk_ts};
      end else begin
        for (int i = NSLOT - 1; i >= 0; i--) begin
          if (slot_v[i] && !wr_en) begin
            grant_slot[i] = 1'b1;
            wr_en         = 1'b1;
            if (i == NUM_STAGES)
              wr_data = {KIND_RETIRE, STAGE_W'(0), slot_id[i], slot_ts[i]};
            else
              wr_data = {KIND_STAGE, STAGE_W'(i), slot_id[i], slot_ts[i]};
          end
        end
      end
    end
  end

  always_comb begin
    n_drop = 16'd0;
    if (enable) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (pulse[i] && slot_v[i] && !grant_slot[i]) n_drop = n_drop + 16'd1;
      end
      if (flush_valid && (state == WALK)) n_drop = n_drop + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ts       <= '0;
      ovf_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (enable) ts <= ts + 1'b1;
      drop_cnt <= sat_add16(drop_cnt, n_drop);
      ovf_cnt  <= grant_ovf ? n_drop : sat_add16(ovf_cnt, n_drop);
    end
  end

  // A granted slot can take a new pulse in the same cycle without losing it.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      slot_v <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_id[i] <= '0;
        slot_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (enable && pulse[i] && (!slot_v[i] || grant_slot[i])) begin
          slot_v[i]  <= 1'b1;
          slot_id[i] <= pulse_id[i];
          slot_ts[i] <= ts;
        end else if (grant_slot[i]) begin
          slot_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      walk_cur  <= '0;
      walk_last <= '0;
      walk_ts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && flush_valid && (flush_first_id <= flush_last_id)) begin
            walk_cur  <= flush_first_id;
            walk_last <= flush_last_id;
            walk_ts   <= ts;
            state     <= WALK;
          end
        end
        WALK: begin
          if (grant_flush) begin
            if (walk_cur == walk_last) state <= IDLE;
            else                       walk_cur <= walk_cur + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign m.tvalid   = !fifo_empty;
  assign m.tdata    = fifo_empty ? '0 : mem[rd_ptr];
  assign drop_count = drop_cnt;
  assign busy       = (|slot_v) || (state == WALK) || !fifo_empty;

endmodule

// File: doc/offnariscv_trace_monitor.md
# offnariscv_trace_monitor

Synthesizable, parametrised pipeline event tracer for the offnariscv core. It watches per-stage handshake acceptances, retirements and flush ranges, and timestamps each one with a free-running cycle counter. Events are serialised through an arbiter into a FIFO and leave on an AXI-Stream master port, so a host can rebuild Kanata-style pipeline logs from silicon or emulation instead of simulator-only tasks. The block sits beside `offnariscv_core` and taps the inter-stage AXIS `ack()` strobes and the writeback `invalidate` path.

## Interface
- `NUM_STAGES`, 6: number of monitored pipeline stages (≥1); `STAGE_W = max(1, $clog2(NUM_STAGES))`
- `ID_WIDTH`, 64: instruction ID width (matches `INST_ID_WIDTH`)
- `TS_WIDTH`, 32: timestamp width
- `FIFO_DEPTH`, 16: event FIFO entries, power of two, ≥4
- `EV_WIDTH` (localparam) = 2 + STAGE_W + ID_WIDTH + TS_WIDTH

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous reset, active-low
- `enable`  in  1  capture and timestamp enable
- `stage_ack`  in  NUM_STAGES  per-stage acceptance pulse (stage i = bit i)
- `stage_id`  in  NUM_STAGES*ID_WIDTH  ID accepted by stage i, slice [i*ID_WIDTH +: ID_WIDTH]
- `retire_valid`  in  1  instruction retired
- `retire_id`  in  ID_WIDTH  retired ID
- `flush_valid`  in  1  squash request
- `flush_first_id`, `flush_last_id`  in  ID_WIDTH each  inclusive squashed ID range
- `m_tvalid`  out  1  event valid
- `m_tready`  in  1  sink ready
- `m_tdata`  out  EV_WIDTH  {kind[1:0], stage[STAGE_W-1:0], id[ID_WIDTH-1:0], ts[TS_WIDTH-1:0]}, MSB first
- `drop_count`  out  16  total dropped events, saturates at 16'hFFFF
- `busy`  out  1  any pending slot, flush walk or FIFO entry non-empty

## Operation
- Event kinds: 0 STAGE (stage = index), 1 RETIRE, 2 FLUSH (one per squashed ID), 3 OVERFLOW (id = drops since last OVERFLOW event, zero-extended; stage = 0). Stage field is 0 for kinds 1–3.
- Timestamp counter `ts`: increments by 1 each cycle while `enable`=1 and wraps modulo 2^TS_WIDTH. It holds while `enable`=0.
- Sources: NUM_STAGES stage slots and one retire slot. Each slot is a one-entry pending register {valid, id, ts}.
  - While `enable`=1, an input pulse loads its slot with the current `ts`.
  - A pulse into an occupied slot that is not granted this cycle is dropped. `drop_count` and the internal `ovf_cnt` increment.
  - If a slot is granted in the same cycle a pulse arrives, the new event is loaded and no drop occurs.
- Flush walker FSM, IDLE/WALK:
  - In IDLE, `flush_valid`&&`enable` with first ≤ last loads `cur`=first, `last`, `fts`=ts and moves to WALK. When first > last, nothing is emitted.
  - In WALK, each grant emits FLUSH{cur, fts}. When cur==last the FSM returns to IDLE; otherwise `cur`++.
  - A `flush_valid` arriving in WALK counts as one drop.
- Arbiter: one FIFO write per cycle, only when the FIFO is not full. Priority, highest first: OVERFLOW (when `ovf_cnt`≠0), flush walker, retire slot, then stage NUM_STAGES-1 down to 0.
- OVERFLOW grant: writes `ovf_cnt` (saturating 16-bit) and clears it. A drop in the same cycle leaves `ovf_cnt`=1.
- FIFO full: there is no grant and slots hold their events. New pulses only drop under the occupied-slot rule.
- `enable`=0: no captures and no drops. Pending slots, the walker and the FIFO keep draining.

## Timing
- Reset (async assert, sync deassert internally) gives: `m_tvalid`=0, `m_tdata`=0, `drop_count`=0, `busy`=0, `ts`=0, all slots empty, walker IDLE, FIFO empty.
- Latency: a pulse in cycle t is captured at the edge ending t, granted in cycle t+1 (if it has top priority and there is room), and shows on `m_tvalid` in cycle t+2. The captured `ts` is the counter value during cycle t.
- AXIS rules:
  - `m_tdata` is stable while `m_tvalid`&&!`m_tready`.
  - `m_tvalid` never drops without a transfer.
  - The FIFO supports a simultaneous read and write when full.
- Throughput: one event per cycle sustained.
- Reset mid-walk or while full discards all state immediately.

## Test plan
- Single stage: `enable`=1, stage_ack[2] pulse with id=5 at ts=10, `m_tready`=1 → one beat kind=0, stage=2, id=5, ts=10 in cycle t+2.
- Collision: stage 0 and stage 5 plus retire id=7, all in the same cycle → beats in order RETIRE(7), STAGE5, STAGE0, all with an identical ts.
- Flush range: first=20, last=23 → FLUSH ids 20, 21, 22, 23 with equal ts. A second flush during the walk gives `drop_count`=1, then an OVERFLOW beat with id=1 ahead of the remaining FLUSH beats.
- Backpressure: `m_tready`=0 for 40 cycles while stage 1 pulses every cycle → FIFO fills (16 beats). Further pulses drop, and `drop_count` equals pulses − 17 (16 in the FIFO plus the one held pending). On release, the data is stable and arrives in order, followed by an OVERFLOW beat carrying the count.
- Empty flush and disable: first=9, last=8 → no beat. With `enable`=0, pulses produce no beats and `ts` holds.
- Async reset asserted mid-stream with the FIFO non-empty → `m_tvalid`=0 and `drop_count`=0 without waiting for a clock edge.
